// File: rtl/dcache_controller.sv
// Sequencing controller for a direct-mapped, one-word-per-line data cache: lookup, refill, write-through, sweeps.
// Load hits return in the lookup cycle; misses and stores stall until memory ack plus one respond cycle.
module dcache_controller #(
  parameter int INDEX_WIDTH = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = DATA_WIDTH - INDEX_WIDTH - 2
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iReq,
  input  logic                   iWE,
  input  logic [DATA_WIDTH-1:0]  iAddress,
  input  logic [DATA_WIDTH-1:0]  iWriteData,
  input  logic                   iFlush,
  output logic                   oStall,
  output logic [DATA_WIDTH-1:0]  oReadData,
  output logic                   oFlushBusy,
  output logic [INDEX_WIDTH-1:0] oIndex,
  input  logic [TAG_WIDTH-1:0]   iTag,
  input  logic                   iV,
  input  logic [DATA_WIDTH-1:0]  iData,
  output logic                   oFill,
  output logic [TAG_WIDTH-1:0]   oFillTag,
  output logic [DATA_WIDTH-1:0]  oFillData,
  output logic                   oInvalidate,
  output logic [INDEX_WIDTH-1:0] oInvIndex,
  output logic                   oMemReq,
  output logic                   oMemWE,
  output logic [DATA_WIDTH-1:0]  oMemAddress,
  output logic [DATA_WIDTH-1:0]  oMemWriteData,
  input  logic                   iMemAck,
  input  logic [DATA_WIDTH-1:0]  iMemReadData,
  output logic [31:0]            oHitCount,
  output logic [31:0]            oMissCount
);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_MISS, S_WRITE, S_RESPOND, S_FLUSH
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_LINE = '1;

  state_t                  state, state_nxt;
  logic [INDEX_WIDTH-1:0]  sweep_cnt;
  logic                    flush_pend;
  logic [DATA_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic [31:0]             hit_cnt;
  logic [31:0]             miss_cnt;

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_idx;
  logic                    hit;
  logic                    flush_go;
  logic                    sweeping;

  assign req_tag  = iAddress[DATA_WIDTH-1:INDEX_WIDTH+2];
  assign req_idx  = iAddress[INDEX_WIDTH+1:2];
  assign hit      = iV && (iTag == req_tag);
  assign flush_go = flush_pend || iFlush;
  assign sweeping = (state == S_CLEAR) || (state == S_FLUSH);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_CLEAR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR, S_FLUSH: if (sweep_cnt == LAST_LINE) state_nxt = S_IDLE;
      S_IDLE: begin
        if (flush_go)     state_nxt = S_FLUSH;
        else if (iReq) begin
          if (iWE)        state_nxt = S_WRITE;
          else if (!hit)  state_nxt = S_MISS;
        end
      end
      S_MISS, S_WRITE:    if (iMemAck) state_nxt = S_RESPOND;
      S_RESPOND:          state_nxt = S_IDLE;
      default:            state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    oStall      = 1'b1;
    oFlushBusy  = sweeping;
    oInvalidate = sweeping;
    oInvIndex   = sweep_cnt;
    oIndex      = lat_addr[INDEX_WIDTH+1:2];
    oReadData   = resp_data;
    oFill       = 1'b0;
    oFillTag    = lat_addr[DATA_WIDTH-1:INDEX_WIDTH+2];
    oFillData   = lat_data;
    oMemReq     = 1'b0;
    oMemWE      = 1'b0;
    case (state)
      S_IDLE: begin
        oIndex    = req_idx;
        oReadData = iData;
        oStall    = iReq && (flush_go || iWE || !hit);
      end
      S_MISS: begin
        oMemReq   = 1'b1;
        oFill     = iMemAck;
        oFillData = iMemReadData;
      end
      S_WRITE: begin
        oMemReq = 1'b1;
        oMemWE  = 1'b1;
        oFill   = iMemAck;
      end
      S_RESPOND: oStall = 1'b0;
      default:   oStall = 1'b1;
    endcase
  end

  assign oMemAddress   = lat_addr;
  assign oMemWriteData = lat_data;
  assign oHitCount     = hit_cnt;
  assign oMissCount    = miss_cnt;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sweep_cnt  <= '0;
      flush_pend <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      resp_data  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      // counter wraps to zero on the last line, ready for the next sweep
      if (sweeping) sweep_cnt <= sweep_cnt + 1'b1;

      if (state == S_IDLE && flush_go)
        flush_pend <= 1'b0;
      else if (iFlush && (state == S_MISS || state == S_WRITE || state == S_RESPOND))
        flush_pend <= 1'b1;

      if (state == S_IDLE && iReq && !flush_go) begin
        if (iWE) begin
          lat_addr <= iAddress;
          lat_data <= iWriteData;
        end else if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          lat_addr <= iAddress;
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
      end

      if (state == S_MISS && iMemAck) resp_data <= iMemReadData;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a cache-array model, directed CPU accesses, and a scoreboard monitor.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] rdata;
  logic        flush_busy;
  logic [3:0]  index;
  logic [25:0] arr_tag;
  logic        arr_v;
  logic [31:0] arr_data;
  logic        fill;
  logic [25:0] fill_tag;
  logic [31:0] fill_data;
  logic        inval;
  logic [3:0]  inv_index;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .iCLK(clk), .iRST(rst), .iReq(req), .iWE(we), .iAddress(addr),
    .iWriteData(wdata), .iFlush(flush), .oStall(stall), .oReadData(rdata),
    .oFlushBusy(flush_busy), .oIndex(index), .iTag(arr_tag), .iV(arr_v),
    .iData(arr_data), .oFill(fill), .oFillTag(fill_tag), .oFillData(fill_data),
    .oInvalidate(inval), .oInvIndex(inv_index), .oMemReq(mem_req),
    .oMemWE(mem_we), .oMemAddress(mem_addr), .oMemWriteData(mem_wdata),
    .iMemAck(mem_ack), .iMemReadData(mem_rdata), .oHitCount(hit_count),
    .oMissCount(miss_count)
  );

  // Array model; lines start valid with junk so a missing clear sweep shows up as false hits.
  logic [25:0] tag_a [16];
  logic        v_a   [16];
  logic [31:0] d_a   [16];
  bit          model_init = 1'b0;

  always @(posedge clk) begin
    if (!model_init) begin
      for (int i = 0; i < 16; i++) begin
        tag_a[i] <= '0;
        v_a[i]   <= 1'b1;
        d_a[i]   <= 32'hA5A5_0000 + i;
      end
      model_init <= 1'b1;
    end else begin
      if (inval) v_a[inv_index] <= 1'b0;
      if (fill) begin
        tag_a[index] <= fill_tag;
        v_a[index]   <= 1'b1;
        d_a[index]   <= fill_data;
      end
    end
  end

  assign arr_tag  = tag_a[index];
  assign arr_v    = v_a[index];
  assign arr_data = d_a[index];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
    logic [31:0] stalls;
  } rsp_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [25:0] tag;
    logic [31:0] data;
  } fill_t;

  rsp_t  rsp_q  [$];
  fill_t fill_q [$];
  int    stall_cnt = 0;

  // Monitor: completions are iReq with oStall low; fills are checked against the fill queue.
  always @(negedge clk) begin
    rsp_t  r;
    fill_t f;
    if (!req) stall_cnt = 0;
    else if (stall) stall_cnt++;
    else begin
      if (rsp_q.size() == 0) chk("unexpected_response", 1, 0);
      else begin
        r = rsp_q.pop_front();
        chk("stall_cycles", stall_cnt, r.stalls);
        if (!r.we) chk("read_data", rdata, r.rdata);
      end
      stall_cnt = 0;
    end
    if (fill) begin
      if (fill_q.size() == 0) chk("unexpected_fill", {index, fill_tag, fill_data}, 0);
      else begin
        f = fill_q.pop_front();
        chk("fill", {index, fill_tag, fill_data}, {f.idx, f.tag, f.data});
      end
    end
  end

  // flush_at: -1 none, 0 with the request in IDLE, 1 in the first MISS cycle
  task automatic access(input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_wdata,
                        input int k, input logic [31:0] mdata, input logic exp_mem,
                        input logic [31:0] exp_rd, input int exp_st, input int flush_at);
    rsp_t  r;
    fill_t f;
    logic  done;
    logic  seen;
    int    mcyc;
    r.we = a_we; r.rdata = exp_rd; r.stalls = exp_st;
    rsp_q.push_back(r);
    if (exp_mem) begin
      f.idx = a_addr[5:2]; f.tag = a_addr[31:6]; f.data = a_we ? a_wdata : mdata;
      fill_q.push_back(f);
    end
    @(posedge clk); #1;
    req = 1'b1; we = a_we; addr = a_addr; wdata = a_wdata;
    if (flush_at == 0) flush = 1'b1;
    done = 1'b0; seen = 1'b0; mcyc = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        seen = 1'b1;
        if (flush_at == 1 && mcyc == 0) flush = 1'b1;
        if (mcyc == k) begin
          mem_ack = 1'b1;
          mem_rdata = mdata;
          chk("mem_we", mem_we, a_we);
          chk("mem_addr", mem_addr, a_addr);
          if (a_we) chk("mem_wdata", mem_wdata, a_wdata);
        end
        mcyc++;
      end
      if (!stall) done = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      flush = 1'b0;
    end
    req = 1'b0;
    chk("access_done", done, 1);
    chk("mem_req_seen", seen, exp_mem);
  endtask

  task automatic count_flush(input int exp_n);
    int n = 0;
    int w = 0;
    @(negedge clk);
    while (!flush_busy && w < 8) begin @(negedge clk); w++; end
    while (flush_busy && n < 40) begin n++; @(negedge clk); end
    chk("flush_cycles", n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clear_sweep", {inval, stall, flush_busy, mem_req, inv_index}, {3'b111, 1'b0, 4'(i)});
    end
    @(negedge clk);
    chk("idle_after_clear", {flush_busy, stall, inval}, 3'b000);
    chk("reset_counts", {hit_count, miss_count}, 64'd0);

    access(1'b0, 32'h44, 32'h0, 2, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 4, -1);
    access(1'b0, 32'h44, 32'h0, 0, 32'h0, 1'b0, 32'hDEADBEEF, 0, -1);
    @(negedge clk);
    chk("counts_1_1", {hit_count, miss_count}, {32'd1, 32'd1});

    access(1'b0, 32'h04, 32'h0, 1, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 3, -1);
    access(1'b0, 32'h44, 32'h0, 0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 2, -1);

    access(1'b1, 32'h08, 32'h12345678, 0, 32'h0, 1'b1, 32'h0, 2, -1);
    access(1'b0, 32'h08, 32'h0, 0, 32'h0, 1'b0, 32'h12345678, 0, -1);
    @(negedge clk);
    chk("counts_2_3", {hit_count, miss_count}, {32'd2, 32'd3});

    access(1'b0, 32'h100, 32'h0, 3, 32'h11112222, 1'b1, 32'h11112222, 5, 1);
    count_flush(16);
    access(1'b0, 32'h100, 32'h0, 0, 32'h33334444, 1'b1, 32'h33334444, 2, -1);

    // flush and request together: 1 idle + 16 sweep + 1 lookup + 1 miss cycle of stall
    access(1'b0, 32'h08, 32'h0, 0, 32'h55556666, 1'b1, 32'h55556666, 19, 0);
    @(negedge clk);
    chk("counts_2_6", {hit_count, miss_count}, {32'd2, 32'd6});

    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 32'h0C;
    for (int c = 0; c < 10 && !mem_req; c++) @(negedge clk);
    chk("midmiss_req", mem_req, 1);
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_abort", {mem_req, inval, stall, inv_index}, {3'b011, 4'd0});
    mem_ack = 1'b1;
    mem_rdata = 32'h77778888;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (20) @(negedge clk);
    chk("reset_counts_again", {hit_count, miss_count}, 64'd0);
    chk("idle_after_reset", {flush_busy, stall}, 2'b00);

    chk("rsp_queue_empty", rsp_q.size(), 0);
    chk("fill_queue_empty", fill_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Sequencing controller for the direct-mapped, one-word-per-line data cache array in the memory stage. It looks up CPU loads and stores, stalls the pipeline on misses and stores, and runs write-through and refill transactions to main memory over a req/ack handshake. It drives the array's fill and invalidate ports, sweeps the array clean after reset and on flush requests, and keeps hit and miss statistics.

## Interface
- INDEX_WIDTH, 4, log2 of the number of cache lines; the index is iAddress[INDEX_WIDTH+1:2].
- DATA_WIDTH, 32, word and address width.
- TAG_WIDTH, DATA_WIDTH-INDEX_WIDTH-2 (26), tag is iAddress[DATA_WIDTH-1:INDEX_WIDTH+2].
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  synchronous, active-high reset.
- iReq  in  1  CPU access request; held with iWE, iAddress and iWriteData stable while oStall=1.
- iWE  in  1  1 means store, 0 means load.
- iAddress  in  DATA_WIDTH  byte address, word aligned.
- iWriteData  in  DATA_WIDTH  store data.
- iFlush  in  1  single-cycle request to invalidate all lines.
- oStall  out  1  pipeline stall.
- oReadData  out  DATA_WIDTH  load result; valid when iReq=1, iWE=0 and oStall=0.
- oFlushBusy  out  1  high while a clear or flush sweep runs.
- oIndex  out  INDEX_WIDTH  array lookup and fill index.
- iTag  in  TAG_WIDTH  array tag at oIndex (combinational read).
- iV  in  1  array valid bit at oIndex.
- iData  in  DATA_WIDTH  array data at oIndex.
- oFill  out  1  write the array at oIndex on this edge: tag, valid=1, data.
- oFillTag  out  TAG_WIDTH  tag to write.
- oFillData  out  DATA_WIDTH  data to write.
- oInvalidate  out  1  clear the valid bit at oInvIndex on this edge.
- oInvIndex  out  INDEX_WIDTH  line to invalidate.
- oMemReq  out  1  memory transaction request, held until ack.
- oMemWE  out  1  memory write (1) or read (0).
- oMemAddress  out  DATA_WIDTH  memory word address (latched request address).
- oMemWriteData  out  DATA_WIDTH  latched store data.
- iMemAck  in  1  one-cycle acknowledge; iMemReadData is valid in the same cycle.
- iMemReadData  in  DATA_WIDTH  refill data.
- oHitCount  out  32  load hits; saturates at 0xFFFFFFFF.
- oMissCount  out  32  load misses; saturates at 0xFFFFFFFF.

## Operation
- The block has six states: CLEAR, IDLE, MISS, WRITE, RESPOND and FLUSH.
- Hit condition: iV=1 and iTag equals the tag field of iAddress.
- **CLEAR** (entered on reset from any state)
  - Sweep counter runs 0 to 2^INDEX_WIDTH-1 with oInvalidate=1 and oInvIndex=counter, one line per cycle.
  - Then go to IDLE. oStall=1 and oFlushBusy=1 throughout.
- **IDLE**
  - oIndex follows iAddress.
  - Pending flush has priority: go to FLUSH with oStall=1 if iReq.
  - Load hit: oReadData=iData, oStall=0 in the same cycle, hit counter +1.
  - Load miss: oStall=1, latch address, miss counter +1, go to MISS.
  - Store (hit or miss): oStall=1, latch address and data, go to WRITE.
- **MISS**
  - oMemReq=1, oMemWE=0. On iMemAck: oFill=1, oFillData=iMemReadData, oFillTag=latched tag; capture the data; go to RESPOND.
- **WRITE**
  - oMemReq=1, oMemWE=1. On iMemAck: oFill=1 with the latched store data and tag (write-allocate); go to RESPOND.
- **RESPOND**
  - oStall=0. For a load, oReadData is the captured refill data. Go to IDLE.
  - The held request is not looked up again.
- **FLUSH**
  - Same sweep as CLEAR, oFlushBusy=1 and oStall=1; then go to IDLE.
- **Flush pending flag**
  - Set by iFlush in MISS, WRITE or RESPOND. Cleared on entry to FLUSH.
  - iFlush during CLEAR or FLUSH is ignored.
- **Outputs outside their states**
  - oFill, oInvalidate and oMemReq are 0 outside the states above.
  - oMemAddress and oMemWriteData always show the latched registers.

## Timing
- **Reset values:** state CLEAR, oStall=1, oFlushBusy=1, oMemReq=0, oFill=0, oInvalidate=1, oInvIndex=0, counters 0, pending flag 0, latches 0, oReadData=0.
- Reset mid-transaction abandons it: oMemReq is low in the first cycle after the reset edge, and a late iMemAck is ignored.
- Reset clear takes 2^INDEX_WIDTH cycles; IDLE is reached at cycle 16 after reset deassertion with the default parameters.
- Load hit: 0 stall cycles.
- Load miss with ack k cycles after MISS entry (k≥0): stall for k+2 cycles, result in the RESPOND cycle. Store: same.
- An iMemAck outside MISS/WRITE is ignored; an ack in the first MISS cycle is legal.
- Flush: 2^INDEX_WIDTH sweep cycles, then IDLE.
- Simultaneous iFlush and iReq in IDLE: flush first, then the request is served.

## Test plan
- **Reset then idle:** after reset, 16 cycles with oInvalidate=1 and oInvIndex 0..15; oStall=1 throughout; oHitCount=0 and oMissCount=0.
- **Load miss then hit:** load to 0x0000_0044 with ack on the 3rd MISS cycle and data 0xDEADBEEF.
  - Fill at index 1, tag 0x000001; stall for 4 cycles; oReadData=0xDEADBEEF.
  - Reloading 0x44 hits with 0 stalls; counters show hits=1, misses=1.
- **Conflict miss:** load 0x04 then 0x44 (same index 1, different tag); the second load misses and refills.
- **Store:** store 0x1234_5678 to 0x08 with immediate ack.
  - oMemWE=1 and oMemAddress=0x08; stall for 2 cycles.
  - A following load of 0x08 hits with 0x12345678 and no memory request.
- **Flush during miss:** iFlush pulse while in MISS; after the ack, RESPOND, then a 16-cycle FLUSH; a following load of the same address misses.
- **Reset mid-miss:** assert iRST while oMemReq=1; the next cycle shows oMemReq=0 and a CLEAR sweep; an ack driven afterwards causes no fill.
